// File: rtl/can_sched_pkg.sv
// Shared types and source encoding for the CAN transmit scheduler.
package can_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    OFFER,
    BUSY
  } sched_state_t;

  localparam logic SRC_HI = 1'b1;
  localparam logic SRC_LO = 1'b0;

endpackage

// File: rtl/can_tx_arb.sv
// Two-queue selector for the Tx scheduler. Fixed high priority by default;
// round-robin with a last-served pointer when CAN_TX_SCHED_RR_EN is defined.
module can_tx_arb
  import can_sched_pkg::*;
(
`ifdef CAN_TX_SCHED_RR_EN
  input  logic clk,
  input  logic reset_n,
  input  logic update,
  input  logic served,
`endif
  input  logic hi_empty,
  input  logic lo_empty,
  output logic any,
  output logic sel
);

  assign any = !hi_empty || !lo_empty;

`ifdef CAN_TX_SCHED_RR_EN
  logic prefer;

  // prefer names the queue that wins the next tie: the one not served last
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prefer <= SRC_HI;
    end else if (update) begin
      prefer <= ~served;
    end
  end

  always_comb begin
    sel = SRC_HI;
    if (hi_empty) begin
      sel = SRC_LO;
    end else if (!lo_empty) begin
      sel = prefer;
    end
  end
`else
  assign sel = hi_empty ? SRC_LO : SRC_HI;
`endif

endmodule

// File: rtl/can_tx_scheduler.sv
// Tx scheduler between the hi/lo Tx FIFOs and the CAN transmitter, with bounded retry.
// Selection policy chosen in can_tx_arb via CAN_TX_SCHED_RR_EN.
//
// state | meaning
// IDLE  | waiting for a non-empty queue; source chosen here
// POP   | read enable to the chosen FIFO
// LATCH | FIFO data valid, captured into o_tx_frame
// OFFER | o_tx_valid high until i_tx_ready
// BUSY  | waiting for i_tx_done / i_tx_fail
module can_tx_scheduler
  import can_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset_n,
  input  logic                  i_hi_empty,
  input  logic [DATA_WIDTH-1:0] i_hi_data,
  output logic                  o_hi_rd_en,
  input  logic                  i_lo_empty,
  input  logic [DATA_WIDTH-1:0] i_lo_data,
  output logic                  o_lo_rd_en,
  output logic [DATA_WIDTH-1:0] o_tx_frame,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  input  logic                  i_tx_done,
  input  logic                  i_tx_fail,
  output logic                  o_src,
  output logic [RETRY_W-1:0]    o_retry_cnt,
  output logic                  o_sent,
  output logic                  o_abort,
  output logic                  o_busy
);

  sched_state_t state, state_d;

  logic                  hi_rd_en_d, lo_rd_en_d, tx_valid_d, src_d, sent_d, abort_d;
  logic [DATA_WIDTH-1:0] tx_frame_d;
  logic [RETRY_W-1:0]    retry_cnt_d;
  logic                  any, sel, at_max;

  can_tx_arb u_arb (
`ifdef CAN_TX_SCHED_RR_EN
    .clk      (i_sys_clk),
    .reset_n  (i_reset_n),
    .update   (state == LATCH),
    .served   (o_src),
`endif
    .hi_empty (i_hi_empty),
    .lo_empty (i_lo_empty),
    .any      (any),
    .sel      (sel)
  );

  assign at_max = (o_retry_cnt == RETRY_W'(MAX_RETRY));

  // Next values of every registered output are computed here so all outputs stay flopped
  always_comb begin
    state_d     = state;
    hi_rd_en_d  = 1'b0;
    lo_rd_en_d  = 1'b0;
    tx_valid_d  = o_tx_valid;
    src_d       = o_src;
    sent_d      = 1'b0;
    abort_d     = 1'b0;
    tx_frame_d  = o_tx_frame;
    retry_cnt_d = o_retry_cnt;
    case (state)
      IDLE: begin
        if (any) begin
          src_d      = sel;
          hi_rd_en_d = (sel == SRC_HI);
          lo_rd_en_d = (sel == SRC_LO);
          state_d    = POP;
        end
      end
      POP: state_d = LATCH;
      LATCH: begin
        tx_frame_d  = (o_src == SRC_HI) ? i_hi_data : i_lo_data;
        retry_cnt_d = '0;
        tx_valid_d  = 1'b1;
        state_d     = OFFER;
      end
      OFFER: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (i_tx_done) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end else if (i_tx_fail) begin
          if (at_max) begin
            abort_d = 1'b1;
            state_d = IDLE;
          end else begin
            retry_cnt_d = o_retry_cnt + RETRY_W'(1);
            tx_valid_d  = 1'b1;
            state_d     = OFFER;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      o_hi_rd_en  <= 1'b0;
      o_lo_rd_en  <= 1'b0;
      o_tx_frame  <= '0;
      o_tx_valid  <= 1'b0;
      o_src       <= 1'b0;
      o_retry_cnt <= '0;
      o_sent      <= 1'b0;
      o_abort     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_hi_rd_en  <= hi_rd_en_d;
      o_lo_rd_en  <= lo_rd_en_d;
      o_tx_frame  <= tx_frame_d;
      o_tx_valid  <= tx_valid_d;
      o_src       <= src_d;
      o_retry_cnt <= retry_cnt_d;
      o_sent      <= sent_d;
      o_abort     <= abort_d;
      o_busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed self-checking bench for can_tx_scheduler with FIFO models on both queues.
module tb_can_tx_scheduler;

  localparam int DW = 128;
  localparam logic [DW-1:0] F_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] F_H1 = {4{32'h1111_0001}};
  localparam logic [DW-1:0] F_H2 = {4{32'h1111_0002}};
  localparam logic [DW-1:0] F_L1 = {4{32'h2222_0001}};
  localparam logic [DW-1:0] F_L2 = {4{32'h2222_0002}};
  localparam logic [DW-1:0] F_R  = {4{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] F_X  = {4{32'h3C3C_5A5A}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          hi_empty = 1'b1, lo_empty = 1'b1;
  logic [DW-1:0] hi_data = '0, lo_data = '0;
  logic          tx_ready = 1'b0, tx_done = 1'b0, tx_fail = 1'b0;
  logic          hi_rd_en, lo_rd_en, tx_valid, src, sent, abort, busy;
  logic [DW-1:0] tx_frame;
  logic [1:0]    retry_cnt;

  logic [DW-1:0] hi_q[$];
  logic [DW-1:0] lo_q[$];

  int errors = 0;
  int checks = 0;
  int hi_rd_cnt = 0, lo_rd_cnt = 0, sent_cnt = 0, abort_cnt = 0;

  can_tx_scheduler dut (
    .i_sys_clk   (clk),
    .i_reset_n   (reset_n),
    .i_hi_empty  (hi_empty),
    .i_hi_data   (hi_data),
    .o_hi_rd_en  (hi_rd_en),
    .i_lo_empty  (lo_empty),
    .i_lo_data   (lo_data),
    .o_lo_rd_en  (lo_rd_en),
    .o_tx_frame  (tx_frame),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .i_tx_done   (tx_done),
    .i_tx_fail   (tx_fail),
    .o_src       (src),
    .o_retry_cnt (retry_cnt),
    .o_sent      (sent),
    .o_abort     (abort),
    .o_busy      (busy)
  );

  // Registered-read FIFO models: data valid the cycle after rd_en
  always @(posedge clk) begin
    if (hi_rd_en && hi_q.size() > 0) hi_data <= hi_q.pop_front();
    if (lo_rd_en && lo_q.size() > 0) lo_data <= lo_q.pop_front();
    hi_rd_cnt <= hi_rd_cnt + (hi_rd_en ? 1 : 0);
    lo_rd_cnt <= lo_rd_cnt + (lo_rd_en ? 1 : 0);
    sent_cnt  <= sent_cnt + (sent ? 1 : 0);
    abort_cnt <= abort_cnt + (abort ? 1 : 0);
  end

  always @(negedge clk) begin
    hi_empty = (hi_q.size() == 0);
    lo_empty = (lo_q.size() == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    tx_ready = 1'b0;
    tx_done  = 1'b0;
    tx_fail  = 1'b0;
    hi_q.delete();
    lo_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hi_q.push_back(F_H1);
    lo_q.push_back(F_L1);
    tick();
    tick();
    checks++;
    if ({busy, hi_rd_en, lo_rd_en, tx_valid, sent, abort, src, retry_cnt} !== 9'b0 || tx_frame !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b hi_rd=%b lo_rd=%b valid=%b sent=%b abort=%b src=%b retry=%0d frame=%h, want all 0",
               busy, hi_rd_en, lo_rd_en, tx_valid, sent, abort, src, retry_cnt, tx_frame);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({busy, hi_rd_en, lo_rd_en, src} !== 4'b1101) begin
      errors++;
      $display("FAIL reset_first_pop: got {busy,hi_rd,lo_rd,src}=%b want 1101", {busy, hi_rd_en, lo_rd_en, src});
    end
    tick();
    checks++;
    if (hi_rd_en !== 1'b0 || hi_rd_cnt !== 1) begin
      errors++;
      $display("FAIL reset_rd_pulse: got hi_rd=%b count=%0d want 0 and 1", hi_rd_en, hi_rd_cnt);
    end
  endtask

  task automatic test_single();
    int lo0, s0, a0;
    lo0 = lo_rd_cnt; s0 = sent_cnt; a0 = abort_cnt;
    lo_q.push_back(F_A5);
    tx_ready = 1'b1;
    tick();
    checks++;
    if ({lo_rd_en, hi_rd_en, src, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL single_pop: got {lo_rd,hi_rd,src,busy}=%b want 1001", {lo_rd_en, hi_rd_en, src, busy});
    end
    tick();
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_frame !== F_A5) begin
      errors++;
      $display("FAIL single_offer: got valid=%b frame=%h want 1 %h", tx_valid, tx_frame, F_A5);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_handshake: got valid=%b busy=%b want 0 1", tx_valid, busy);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if ({sent, abort, busy} !== 3'b100) begin
      errors++;
      $display("FAIL single_sent: got {sent,abort,busy}=%b want 100", {sent, abort, busy});
    end
    tick();
    checks++;
    if (sent !== 1'b0 || lo_rd_cnt - lo0 !== 1 || sent_cnt - s0 !== 1 || abort_cnt - a0 !== 0) begin
      errors++;
      $display("FAIL single_counts: got sent=%b pops=%0d sents=%0d aborts=%0d want 0 1 1 0",
               sent, lo_rd_cnt - lo0, sent_cnt - s0, abort_cnt - a0);
    end
  endtask

  task automatic test_retry();
    int s0, a0;
    s0 = sent_cnt; a0 = abort_cnt;
    hi_q.push_back(F_R);
    tx_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (retry_cnt !== 2'd0 || tx_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL retry_start: got retry=%0d valid=%b busy=%b want 0 0 1", retry_cnt, tx_valid, busy);
    end
    for (int i = 1; i <= 2; i++) begin
      tx_fail = 1'b1;
      tick();
      tx_fail = 1'b0;
      checks++;
      if (retry_cnt !== 2'(i) || tx_valid !== 1'b1 || tx_frame !== F_R || sent !== 1'b0) begin
        errors++;
        $display("FAIL retry_reoffer%0d: got retry=%0d valid=%b frame=%h sent=%b want %0d 1 %h 0",
                 i, retry_cnt, tx_valid, tx_frame, sent, i, F_R);
      end
      tick();
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    checks++;
    if (sent_cnt - s0 !== 1 || abort_cnt - a0 !== 0) begin
      errors++;
      $display("FAIL retry_result: got sents=%0d aborts=%0d want 1 0", sent_cnt - s0, abort_cnt - a0);
    end
  endtask

  task automatic test_abort();
    int s0, a0;
    a0 = abort_cnt;
    hi_q.push_back(F_R);
    lo_q.push_back(F_X);
    tx_ready = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      tx_fail = 1'b1;
      tick();
      tx_fail = 1'b0;
      if (i < 3) begin
        checks++;
        if (retry_cnt !== 2'(i + 1) || tx_valid !== 1'b1 || abort !== 1'b0) begin
          errors++;
          $display("FAIL abort_retry%0d: got retry=%0d valid=%b abort=%b want %0d 1 0",
                   i, retry_cnt, tx_valid, abort, i + 1);
        end
        tick();
      end
    end
    checks++;
    if ({abort, sent, busy, tx_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_pulse: got {abort,sent,busy,valid}=%b want 1000", {abort, sent, busy, tx_valid});
    end
    tick();
    checks++;
    if ({abort, lo_rd_en, hi_rd_en} !== 3'b010 || abort_cnt - a0 !== 1) begin
      errors++;
      $display("FAIL abort_next_pop: got {abort,lo_rd,hi_rd}=%b aborts=%0d want 010 1",
               {abort, lo_rd_en, hi_rd_en}, abort_cnt - a0);
    end
    tick();
    tick();
    checks++;
    if (tx_frame !== F_X || src !== 1'b0 || tx_valid !== 1'b1 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL abort_next_frame: got frame=%h src=%b valid=%b retry=%0d want %h 0 1 0",
               tx_frame, src, tx_valid, retry_cnt, F_X);
    end
    tick();
    s0 = sent_cnt; a0 = abort_cnt;
    tx_done = 1'b1;
    tx_fail = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_fail = 1'b0;
    tick();
    checks++;
    if (sent_cnt - s0 !== 1 || abort_cnt - a0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_and_fail: got sents=%0d aborts=%0d busy=%b want 1 0 0", sent_cnt - s0, abort_cnt - a0, busy);
    end
  endtask

  task automatic test_busy_reset();
    int s0, a0, h0;
    hi_q.push_back(F_H2);
    tx_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_reset_pre: got busy=%b valid=%b want 1 0", busy, tx_valid);
    end
    s0 = sent_cnt; a0 = abort_cnt;
    reset_n = 1'b0;
    tx_done = 1'b1;
    tx_fail = 1'b1;
    tick();
    h0 = hi_rd_cnt;
    checks++;
    if ({busy, hi_rd_en, lo_rd_en, tx_valid, sent, abort, src, retry_cnt} !== 9'b0 || tx_frame !== '0) begin
      errors++;
      $display("FAIL busy_reset_outputs: got busy=%b valid=%b sent=%b abort=%b src=%b retry=%0d frame=%h want all 0",
               busy, tx_valid, sent, abort, src, retry_cnt, tx_frame);
    end
    reset_n = 1'b1;
    tx_done = 1'b0;
    tx_fail = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || sent_cnt !== s0 || abort_cnt !== a0 || hi_rd_cnt !== h0) begin
      errors++;
      $display("FAIL busy_reset_after: got busy=%b sents=%0d aborts=%0d pops=%0d want 0 %0d %0d %0d",
               busy, sent_cnt, abort_cnt, hi_rd_cnt, s0, a0, h0);
    end
  endtask

  task automatic test_priority();
    logic [DW-1:0] exp_order[4];
`ifdef CAN_TX_SCHED_RR_EN
    exp_order = '{F_H1, F_L1, F_H2, F_L2};
`else
    exp_order = '{F_H1, F_H2, F_L1, F_L2};
`endif
    do_reset();
    hi_q.push_back(F_H1);
    hi_q.push_back(F_H2);
    lo_q.push_back(F_L1);
    lo_q.push_back(F_L2);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 10 && tx_valid !== 1'b1; k++) tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_frame !== exp_order[i]) begin
        errors++;
        $display("FAIL order%0d: got valid=%b frame=%h want 1 %h", i, tx_valid, tx_frame, exp_order[i]);
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      checks++;
      if (sent !== 1'b1) begin
        errors++;
        $display("FAIL order_sent%0d: got sent=%b want 1", i, sent);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    do_reset();
    test_single();
    test_retry();
    test_abort();
    test_busy_reset();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
